// File: rtl/mul_result_stage_if.sv
// Handshake bundle between the multiplier result stage and its producer/consumer.
// slave is the stage's view; master is the view of the logic driving/consuming it.
interface mul_result_stage_if #(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [2*W-1:0]   in_prod;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_lo;
  logic [W-1:0]     out_hi;
  logic             out_zero;
  logic             out_ovf;
  logic [CW-1:0]    count;
  logic [CNT_W-1:0] ovf_cnt;

  modport slave (
    input  in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_lo, out_hi, out_zero, out_ovf, count, ovf_cnt
  );

  modport master (
    output in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_lo, out_hi, out_zero, out_ovf, count, ovf_cnt
  );
endinterface

// File: rtl/mul_result_stage.sv
// Buffers 2W-bit products in a DEPTH-entry FIFO, splits HI/LO, flags zero/overflow; head visible one edge after push,
// in_ready is registered (full blocks push even with a same-cycle pop). MUL_SAT_EN saturates out_lo on overflow.
module mul_result_stage #(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  mul_result_stage_if.slave       bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [2*W-1:0]   prod_mem [DEPTH];
  logic             zero_mem [DEPTH];
  logic             ovf_mem  [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [CNT_W-1:0] ovf_q;

  logic             not_full;
  logic             not_empty;
  logic             push;
  logic             pop;
  logic             in_ovf;
  logic             in_zero;

  assign not_full  = (cnt != CW'(DEPTH));
  assign not_empty = (cnt != '0);
  // Reset cycle completes no handshake, so both strobes are gated by rst.
  assign push      = bus.in_valid && not_full && !rst;
  assign pop       = bus.out_ready && not_empty && !rst;
  assign in_ovf    = |bus.in_prod[2*W-1:W];
  assign in_zero   = ~|bus.in_prod;

  always_ff @(posedge clk) begin
    if (push) begin
      prod_mem[wr_ptr] <= bus.in_prod;
      zero_mem[wr_ptr] <= in_zero;
      ovf_mem[wr_ptr]  <= in_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        cnt <= cnt + CW'(1);
      end else if (pop && !push) begin
        cnt <= cnt - CW'(1);
      end
      if (push && in_ovf && (ovf_q != {CNT_W{1'b1}})) begin
        ovf_q <= ovf_q + CNT_W'(1);
      end
    end
  end

  logic [2*W-1:0] head_prod;
  logic           head_zero;
  logic           head_ovf;
  logic [W-1:0]   lo_q;
  logic [W-1:0]   hi_q;

  always_comb begin
    head_prod = '0;
    head_zero = 1'b0;
    head_ovf  = 1'b0;
    if (not_empty) begin
      head_prod = prod_mem[rd_ptr];
      head_zero = zero_mem[rd_ptr];
      head_ovf  = ovf_mem[rd_ptr];
    end
    hi_q = head_prod[2*W-1:W];
`ifdef MUL_SAT_EN
    lo_q = head_ovf ? {W{1'b1}} : head_prod[W-1:0];
`else
    lo_q = head_prod[W-1:0];
`endif
  end

  assign bus.in_ready  = not_full;
  assign bus.out_valid = not_empty;
  assign bus.out_lo    = lo_q;
  assign bus.out_hi    = hi_q;
  assign bus.out_zero  = head_zero;
  assign bus.out_ovf   = head_ovf;
  assign bus.count     = cnt;
  assign bus.ovf_cnt   = ovf_q;
endmodule

// File: tb/tb_mul_result_stage.sv
// Bench for mul_result_stage: queue model checked every cycle plus literal expectations per scenario.
module tb_mul_result_stage;
  localparam int W     = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk;
  logic rst;
  mul_result_stage_if #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  mul_result_stage #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int failed = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: products in arrival order plus a saturating overflow tally.
  logic [63:0] mq[$];
  int          m_ovf = 0;

  always @(posedge clk) begin
    bit do_push;
    bit do_pop;
    if (rst) begin
      mq.delete();
      m_ovf = 0;
    end else begin
      do_push = bus.in_valid && (mq.size() < DEPTH);
      do_pop  = bus.out_ready && (mq.size() > 0);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(bus.in_prod);
        if (bus.in_prod[63:32] != 0 && m_ovf < MAXC) m_ovf++;
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] h;
    logic [31:0] exp_lo;
    if (started) begin
      check("m_valid", bus.out_valid, mq.size() != 0);
      check("m_ready", bus.in_ready, mq.size() != DEPTH);
      check("m_count", bus.count, mq.size());
      check("m_ovfcnt", bus.ovf_cnt, m_ovf);
      h = (mq.size() != 0) ? mq[0] : 64'd0;
      exp_lo = h[31:0];
`ifdef MUL_SAT_EN
      if (h[63:32] != 0) exp_lo = 32'hFFFF_FFFF;
`endif
      check("m_lo", bus.out_lo, exp_lo);
      check("m_hi", bus.out_hi, h[63:32]);
      check("m_zero", bus.out_zero, (mq.size() != 0) && (h == 0));
      check("m_ovf", bus.out_ovf, h[63:32] != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_prod   = '0;
    bus.out_ready = 1'b0;
    tick();
    started = 1'b1;
    rst = 1'b0;
    check("rst_valid", bus.out_valid, 0);
    check("rst_ready", bus.in_ready, 1);
    check("rst_count", bus.count, 0);
    check("rst_ovfcnt", bus.ovf_cnt, 0);
    check("rst_lo", bus.out_lo, 0);
    check("rst_hi", bus.out_hi, 0);

    // Single product, consumer ready
    bus.in_valid = 1'b1; bus.in_prod = 64'h6; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("t2_valid", bus.out_valid, 1);
    check("t2_lo", bus.out_lo, 6);
    check("t2_hi", bus.out_hi, 0);
    check("t2_ovf", bus.out_ovf, 0);
    check("t2_zero", bus.out_zero, 0);
    tick();
    check("t2_count", bus.count, 0);

    // Fill with consumer stalled; third push refused
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_prod = 64'h1; tick();
    bus.in_prod = 64'h2; tick();
    bus.in_prod = 64'h3; tick();
    bus.in_valid = 1'b0;
    check("t3_count", bus.count, 2);
    check("t3_ready", bus.in_ready, 0);
    check("t3_head1", bus.out_lo, 1);
    tick();
    check("t3_hold", bus.out_lo, 1);
    bus.out_ready = 1'b1;
    tick();
    check("t3_head2", bus.out_lo, 2);
    check("t3_count1", bus.count, 1);
    tick();
    check("t3_empty", bus.out_valid, 0);
    bus.out_ready = 1'b0;

    // Overflowing product
    bus.in_valid = 1'b1; bus.in_prod = 64'h0000_0001_0000_0005;
    tick();
    bus.in_valid = 1'b0;
    check("t4_hi", bus.out_hi, 1);
    check("t4_ovf", bus.out_ovf, 1);
    check("t4_ovfcnt", bus.ovf_cnt, 1);
`ifdef MUL_SAT_EN
    check("t4_lo", bus.out_lo, 32'hFFFF_FFFF);
`else
    check("t4_lo", bus.out_lo, 5);
`endif
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Zero product, then steady stream
    bus.in_valid = 1'b1; bus.in_prod = 64'h0;
    tick();
    check("t5_zero", bus.out_zero, 1);
    check("t5_ovf", bus.out_ovf, 0);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.in_prod = 64'(i * 3);
      tick();
      check("t5_stream_cnt", bus.count, 1);
      check("t5_stream_lo", bus.out_lo, 32'(i * 3));
    end
    bus.in_valid = 1'b0;
    tick();
    check("t5_drain", bus.count, 0);

    // Reset while full
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_prod = 64'h2_0000_0000;
    tick(); tick();
    check("t6_full", bus.count, 2);
    check("t6_ovfcnt_pre", bus.ovf_cnt, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("t6_count", bus.count, 0);
    check("t6_valid", bus.out_valid, 0);
    check("t6_ovfcnt", bus.ovf_cnt, 0);

    // Drive overflow counter past its ceiling
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_prod = 64'hFFFF_FFFF_0000_0000;
    for (int i = 0; i < MAXC + 5; i++) tick();
    bus.in_valid = 1'b0;
    check("t6_sat", bus.ovf_cnt, MAXC);
    tick();
    tick();
    check("t6_sat_hold", bus.ovf_cnt, MAXC);
    check("t6_final_empty", bus.out_valid, 0);

    @(posedge clk);
    $display("%0d/%0d checks passed", total - failed, total);
    $finish;
  end
endmodule
